ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester round-robin arbiter that shares the single-port byte RAM between two masters, e.g. instruction fetch (port 0) and load/store (port 1). It accepts one access per cycle through a valid/ready handshake, drives registered command signals into the RAM, and returns read data to the issuing port with a fixed latency. It also suppresses accesses beyond the RAM depth.

## Interface
- MEM_LENGTH, 255, highest valid RAM address; must match the RAM instance.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  port request; must be held with its command until accepted.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  16  byte address.
- wdata0 / wdata1  in  8  write data.
- gnt0 / gnt1  out  1  combinational ready; the transfer occurs at the rising edge where reqN & gntN.
- rvalid0 / rvalid1  out  1  one-cycle pulse; rdataN is valid.
- rdata0 / rdata1  out  8  read data; the same value is driven to both ports, and only rvalid qualifies it.
- ram_address  out  16  to RAM address.
- ram_data_in  out  8  to RAM data_in.
- ram_write_enable  out  1  to RAM write_enable.
- ram_read_enable  out  1  to RAM read_enable.
- ram_data_out  in  8  from RAM data_out (registered inside the RAM).

## Operation
- State: last (1 bit, port granted most recently), a registered RAM command, rd_pend, rd_port, rd_oob.
- Arbitration (combinational, every cycle):
  - Only req0 high: gnt0 = 1.
  - Only req1 high: gnt1 = 1.
  - Both high: grant the port != last.
  - Neither high: no grant.
  - gnt0 and gnt1 are never both high.
- Accept edge for port N:
  - last <= N.
  - ram_address <= addrN and ram_data_in <= wdataN.
  - In range (addrN <= MEM_LENGTH): ram_write_enable <= weN; ram_read_enable <= ~weN.
  - Out of range: both enables <= 0. The write is dropped.
  - Reads: rd_pend <= 1, rd_port <= N, rd_oob <= out-of-range flag.
- No accept that edge: both enables <= 0. Address and data registers hold their values.
- Read return: at the edge after the RAM command cycle, rvalid[rd_port] <= rd_pend. rdata = rd_oob_q ? 8'h00 : ram_data_out.
  - rd_oob_q is rd_oob delayed in lockstep with rvalid.
- Writes produce no response.
- The arbiter has no backpressure on read return. Requesters must always accept rvalid.

## Timing
- Reset (async, rst_n low): all outputs 0 (ram_address 0, ram_data_in 0, both enables 0, rvalid 0, rdata 0).
  - last <= 1, so port 0 wins the first contention.
  - Pending reads are discarded.
  - gnt is held 0 while rst_n is low.
- Pipeline for a handshake at edge E0:
  - The RAM command is driven in cycle E0..E1.
  - The RAM samples at E1.
  - rvalid and rdata are high in cycle E1..E2.
  - Read latency is therefore 2 edges from accept.
- Throughput: one access per cycle. Back-to-back accepts from the same or alternating ports are legal. Read returns are pipelined, one per cycle, in issue order.
- Both ports requesting continuously: grants alternate 0,1,0,1...
- A single port requesting continuously: granted every cycle.
- Read then write to the same address on consecutive accepts: the read returns the old data (RAM semantics).
- Write then read to the same address: the read returns the new data.
- Address exactly MEM_LENGTH: in range. MEM_LENGTH+1 through 16'hFFFF: out of range.
- rst_n asserted mid-pipeline: the command in flight is cancelled (enables forced 0). No rvalid follows reset release.

## Test plan
- Reset, then req0 read addr 0x0010 (RAM preloaded 0x5A) -> gnt0 same cycle; ram_read_enable=1 next cycle; rvalid0=1, rdata0=0x5A two edges after accept; rvalid1 stays 0.
- Both ports request continuously for 6 cycles (port0 reads 0x00..0x02, port1 writes 0xA0..0xA2 to 0x20..0x22) -> grants 0,1,0,1,0,1; RAM holds 0xA0..0xA2; port0 receives 3 rvalid pulses in order.
- Port1 writes 0x33 to 0x0040, then immediately reads 0x0040 -> rvalid1 with rdata1=0x33.
- Port0 write to 0x0100 (MEM_LENGTH=255) -> accepted, ram_write_enable stays 0, memory unchanged; port0 read 0x0100 -> rvalid0 with rdata0=0x00; read 0x00FF returns stored data.
- Read accepted, rst_n pulsed low during the command cycle -> all outputs 0 immediately; no rvalid after release; first contention grants port0.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the RAM arbiter: one instance per port.
interface ram_arbiter_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  // Requester drives the command and sees grant / read return.
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  // Arbiter sees the command and drives grant / read return.
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port byte RAM.
// One access per cycle, registered RAM command, read data returned two
// edges after accept; addresses beyond MEM_LENGTH never reach the RAM.
module ram_arbiter #(
  parameter  int unsigned MEM_LENGTH = 255,
  localparam int unsigned ADDR_W     = 16,
  localparam int unsigned DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_arbiter_if.slave      p0_if,
  ram_arbiter_if.slave      p1_if,
  output logic [ADDR_W-1:0] ram_address_o,
  output logic [DATA_W-1:0] ram_data_in_o,
  output logic              ram_write_enable_o,
  output logic              ram_read_enable_o,
  input  logic [DATA_W-1:0] ram_data_out_i
);

  logic              last_q,       last_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic              we_q,         we_d;
  logic              re_q,         re_d;
  logic              rd_pend_q,    rd_pend_d;
  logic              rd_port_q,    rd_port_d;
  logic              rd_oob_q,     rd_oob_d;
  logic [1:0]        rvalid_q,     rvalid_d;
  logic              rd_oob_dly_q, rd_oob_dly_d;

  logic              gnt0_c;
  logic              gnt1_c;
  logic              accept_c;
  logic              sel_c;
  logic              sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;
  logic              oob_c;
  logic [DATA_W-1:0] rdata_c;

  // Round-robin grant; on contention the port not served last wins.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (rst_n) begin
      if (p0_if.req && p1_if.req) begin
        gnt0_c = last_q;
        gnt1_c = ~last_q;
      end else begin
        gnt0_c = p0_if.req;
        gnt1_c = p1_if.req;
      end
    end
  end

  // Select the command of the granted port and classify its address.
  always_comb begin
    accept_c    = gnt0_c | gnt1_c;
    sel_c       = gnt1_c;
    sel_we_c    = sel_c ? p1_if.we    : p0_if.we;
    sel_addr_c  = sel_c ? p1_if.addr  : p0_if.addr;
    sel_wdata_c = sel_c ? p1_if.wdata : p0_if.wdata;
    oob_c       = sel_addr_c > ADDR_W'(MEM_LENGTH);
  end

  // Next-state: RAM command stage and the two-stage read-return pipeline.
  always_comb begin
    last_d       = last_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = 1'b0;
    re_d         = 1'b0;
    rd_pend_d    = 1'b0;
    rd_port_d    = rd_port_q;
    rd_oob_d     = rd_oob_q;
    rvalid_d     = {rd_pend_q & rd_port_q, rd_pend_q & ~rd_port_q};
    rd_oob_dly_d = rd_oob_q;
    if (accept_c) begin
      last_d  = sel_c;
      addr_d  = sel_addr_c;
      wdata_d = sel_wdata_c;
      we_d    = sel_we_c & ~oob_c;
      re_d    = ~sel_we_c & ~oob_c;
      if (!sel_we_c) begin
        rd_pend_d = 1'b1;
        rd_port_d = sel_c;
        rd_oob_d  = oob_c;
      end
    end
  end

  // State registers; reset cancels any command or read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_port_q    <= 1'b0;
      rd_oob_q     <= 1'b0;
      rvalid_q     <= '0;
      rd_oob_dly_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      re_q         <= re_d;
      rd_pend_q    <= rd_pend_d;
      rd_port_q    <= rd_port_d;
      rd_oob_q     <= rd_oob_d;
      rvalid_q     <= rvalid_d;
      rd_oob_dly_q <= rd_oob_dly_d;
    end
  end

  // Read data straight from the RAM's output register, zeroed for
  // out-of-range reads and held at zero whenever no return is valid.
  always_comb begin
    rdata_c = '0;
    if ((|rvalid_q) && !rd_oob_dly_q) rdata_c = ram_data_out_i;
  end

  assign p0_if.gnt    = gnt0_c;
  assign p1_if.gnt    = gnt1_c;
  assign p0_if.rvalid = rvalid_q[0];
  assign p1_if.rvalid = rvalid_q[1];
  assign p0_if.rdata  = rdata_c;
  assign p1_if.rdata  = rdata_c;

  assign ram_address_o      = addr_q;
  assign ram_data_in_o      = wdata_q;
  assign ram_write_enable_o = we_q;
  assign ram_read_enable_o  = re_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model (grant rule, shadow memory, return queue).
module tb_ram_arbiter;
  localparam int unsigned MEM_LENGTH = 255;

  logic        clk;
  logic        rst_n;
  logic [15:0] ram_address;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out;
  logic        ram_we;
  logic        ram_re;

  ram_arbiter_if p0_if ();
  ram_arbiter_if p1_if ();

  // RAM device with a backdoor write port for preloading.
  logic [7:0] mem [256];
  logic       bd_we;
  logic [7:0] bd_addr;
  logic [7:0] bd_data;

  int checks;
  int errors;

  // Transaction model state.
  bit         m_last;
  logic [7:0] shadow [256];
  bit         st1_v, st1_port, st2_v, st2_port;
  logic [7:0] st1_data, st2_data;

  ram_arbiter #(.MEM_LENGTH(MEM_LENGTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .p0_if              (p0_if),
    .p1_if              (p1_if),
    .ram_address_o      (ram_address),
    .ram_data_in_o      (ram_data_in),
    .ram_write_enable_o (ram_we),
    .ram_read_enable_o  (ram_re),
    .ram_data_out_i     (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_address[7:0]] <= ram_data_in;
    if (ram_re) ram_data_out <= mem[ram_address[7:0]];
  end

  function automatic bit in_range(input logic [15:0] a);
    return 32'(a) <= MEM_LENGTH;
  endfunction

  // Expected {gnt1, gnt0}: lone requester wins, contention goes to the other port.
  function automatic logic [1:0] exp_gnt(input logic r0, input logic r1);
    if (r0 && r1) return m_last ? 2'b01 : 2'b10;
    return {r1, r0};
  endfunction

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 16'h00FF;
      1:       return 16'h0100;
      2:       return 16'hFFFF;
      3:       return 16'($urandom_range(256, 65535));
      default: return 16'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic model_reset();
    m_last = 1'b1;
    st1_v  = 1'b0;
    st2_v  = 1'b0;
  endtask

  // Advance one clock from a negedge to the next, applying the accept to the model.
  task automatic clk_step();
    logic [1:0]  eg;
    bit          port;
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
    eg = exp_gnt(p0_if.req, p1_if.req);
    @(posedge clk);
    st2_v = st1_v; st2_port = st1_port; st2_data = st1_data;
    st1_v = 1'b0;
    if (eg != 2'b00) begin
      port   = eg[1];
      a      = port ? p1_if.addr  : p0_if.addr;
      w      = port ? p1_if.we    : p0_if.we;
      d      = port ? p1_if.wdata : p0_if.wdata;
      m_last = port;
      if (w) begin
        if (in_range(a)) shadow[a[7:0]] = d;
      end else begin
        st1_v    = 1'b1;
        st1_port = port;
        st1_data = in_range(a) ? shadow[a[7:0]] : 8'h00;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    p0_if.req = 1'b1; p1_if.req = 1'b1;
    #1;
    checks++;
    if ({p1_if.gnt, p0_if.gnt} !== 2'b00) begin
      errors++; $display("FAIL reset_gnt got=%b exp=00", {p1_if.gnt, p0_if.gnt});
    end
    checks++;
    if (ram_address !== 16'h0 || ram_data_in !== 8'h0 || ram_we !== 1'b0 || ram_re !== 1'b0) begin
      errors++;
      $display("FAIL reset_ram got addr=%h din=%h we=%b re=%b exp all 0", ram_address, ram_data_in, ram_we, ram_re);
    end
    checks++;
    if (p0_if.rvalid !== 1'b0 || p1_if.rvalid !== 1'b0 || p0_if.rdata !== 8'h0 || p1_if.rdata !== 8'h0) begin
      errors++;
      $display("FAIL reset_ret got rv=%b%b rd0=%h rd1=%h exp 0", p1_if.rvalid, p0_if.rvalid, p0_if.rdata, p1_if.rdata);
    end
    p0_if.req = 1'b0; p1_if.req = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int i0, i1, pulses;
    i0 = 0; i1 = 0; pulses = 0;
    for (int k = 0; k < 9; k++) begin
      if (k < 6) begin
        p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 16'(i0);
        p1_if.req = 1'b1; p1_if.we = 1'b1; p1_if.addr = 16'h0020 + 16'(i1);
        p1_if.wdata = 8'hA0 + 8'(i1);
      end else begin
        p0_if.req = 1'b0; p1_if.req = 1'b0;
      end
      #1;
      if (k < 6) begin
        checks++;
        if ({p1_if.gnt, p0_if.gnt} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL contention_gnt k=%0d got=%b", k, {p1_if.gnt, p0_if.gnt});
        end
      end
      checks++;
      if (p0_if.rvalid !== (st2_v & ~st2_port) || p1_if.rvalid !== (st2_v & st2_port) ||
          (st2_v && p0_if.rdata !== st2_data)) begin
        errors++;
        $display("FAIL contention_ret k=%0d got rv=%b%b rd=%h exp v=%b port=%b rd=%h",
                 k, p1_if.rvalid, p0_if.rvalid, p0_if.rdata, st2_v, st2_port, st2_data);
      end
      if (p0_if.rvalid === 1'b1) pulses++;
      clk_step();
      if (k < 6) begin
        if (k % 2 == 0) i0++;
        else i1++;
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++; $display("FAIL contention_pulses got=%0d exp=3", pulses);
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (mem[8'h20 + 8'(j)] !== 8'hA0 + 8'(j)) begin
        errors++; $display("FAIL contention_mem addr=%h got=%h exp=%h", 8'h20 + 8'(j), mem[8'h20 + 8'(j)], 8'hA0 + 8'(j));
      end
    end
  endtask

  task automatic test_single_read();
    p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 16'h0010;
    #1;
    checks++;
    if (p0_if.gnt !== 1'b1 || p1_if.gnt !== 1'b0) begin
      errors++; $display("FAIL single_gnt got=%b%b exp=01", p1_if.gnt, p0_if.gnt);
    end
    clk_step();
    p0_if.req = 1'b0;
    checks++;
    if (ram_re !== 1'b1 || ram_we !== 1'b0 || ram_address !== 16'h0010) begin
      errors++; $display("FAIL single_cmd got re=%b we=%b addr=%h exp 1 0 0010", ram_re, ram_we, ram_address);
    end
    checks++;
    if (p0_if.rvalid !== 1'b0) begin
      errors++; $display("FAIL single_early got rvalid0=%b exp=0", p0_if.rvalid);
    end
    clk_step();
    checks++;
    if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== 8'h5A || p1_if.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_ret got rv0=%b rd0=%h rv1=%b exp 1 5a 0", p0_if.rvalid, p0_if.rdata, p1_if.rvalid);
    end
    clk_step();
    checks++;
    if (p0_if.rvalid !== 1'b0) begin
      errors++; $display("FAIL single_pulse got rvalid0=%b exp=0", p0_if.rvalid);
    end
  endtask

  task automatic test_write_read();
    p1_if.req = 1'b1; p1_if.we = 1'b1; p1_if.addr = 16'h0040; p1_if.wdata = 8'h33;
    #1;
    checks++;
    if (p1_if.gnt !== 1'b1 || p0_if.gnt !== 1'b0) begin
      errors++; $display("FAIL wr_gnt got=%b%b exp=10", p1_if.gnt, p0_if.gnt);
    end
    clk_step();
    p1_if.we = 1'b0;
    clk_step();
    p1_if.req = 1'b0;
    clk_step();
    checks++;
    if (p1_if.rvalid !== 1'b1 || p1_if.rdata !== 8'h33 || p0_if.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd got rv1=%b rd1=%h rv0=%b exp 1 33 0", p1_if.rvalid, p1_if.rdata, p0_if.rvalid);
    end
  endtask

  task automatic test_oob();
    logic [7:0] keep0;
    keep0 = shadow[8'h00];
    p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 16'h0100; p0_if.wdata = 8'hEE;
    #1;
    checks++;
    if (p0_if.gnt !== 1'b1) begin
      errors++; $display("FAIL oob_gnt got=%b exp=1", p0_if.gnt);
    end
    clk_step();
    checks++;
    if (ram_we !== 1'b0 || ram_re !== 1'b0) begin
      errors++; $display("FAIL oob_wr_en got we=%b re=%b exp 0 0", ram_we, ram_re);
    end
    p0_if.we = 1'b0;
    clk_step();
    checks++;
    if (ram_re !== 1'b0) begin
      errors++; $display("FAIL oob_rd_en got re=%b exp=0", ram_re);
    end
    p0_if.addr = 16'h00FF;
    clk_step();
    p0_if.req = 1'b0;
    checks++;
    if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== 8'h00) begin
      errors++; $display("FAIL oob_rd got rv0=%b rd0=%h exp 1 00", p0_if.rvalid, p0_if.rdata);
    end
    checks++;
    if (ram_re !== 1'b1) begin
      errors++; $display("FAIL edge_rd_en got re=%b exp=1", ram_re);
    end
    clk_step();
    checks++;
    if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== shadow[8'hFF]) begin
      errors++; $display("FAIL edge_rd got rv0=%b rd0=%h exp 1 %h", p0_if.rvalid, p0_if.rdata, shadow[8'hFF]);
    end
    checks++;
    if (mem[8'h00] !== keep0) begin
      errors++; $display("FAIL oob_mem got=%h exp=%h", mem[8'h00], keep0);
    end
  endtask

  task automatic test_reset_midpipe();
    p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 16'h0011;
    clk_step();
    p0_if.req = 1'b0;
    rst_n = 1'b0;
    p0_if.req = 1'b1; p1_if.req = 1'b1;
    #1;
    checks++;
    if (ram_re !== 1'b0 || ram_we !== 1'b0 || ram_address !== 16'h0 || p0_if.rvalid !== 1'b0 || p0_if.rdata !== 8'h0) begin
      errors++;
      $display("FAIL midrst_out got re=%b we=%b addr=%h rv0=%b rd0=%h exp all 0", ram_re, ram_we, ram_address, p0_if.rvalid, p0_if.rdata);
    end
    checks++;
    if ({p1_if.gnt, p0_if.gnt} !== 2'b00) begin
      errors++; $display("FAIL midrst_gnt got=%b exp=00", {p1_if.gnt, p0_if.gnt});
    end
    repeat (2) @(negedge clk);
    p0_if.req = 1'b0; p1_if.req = 1'b0;
    model_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (p0_if.rvalid !== 1'b0 || p1_if.rvalid !== 1'b0) begin
        errors++; $display("FAIL midrst_rvalid k=%0d got=%b%b exp=00", k, p1_if.rvalid, p0_if.rvalid);
      end
      clk_step();
    end
    p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 16'h0001;
    p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 16'h0002;
    #1;
    checks++;
    if ({p1_if.gnt, p0_if.gnt} !== 2'b01) begin
      errors++; $display("FAIL midrst_first got=%b exp=01", {p1_if.gnt, p0_if.gnt});
    end
    clk_step();
    p0_if.req = 1'b0;
    clk_step();
    p1_if.req = 1'b0;
    repeat (2) clk_step();
  endtask

  task automatic test_random();
    logic [1:0] eg;
    int         bad;
    for (int c = 0; c < 400; c++) begin
      if (!p0_if.req && $urandom_range(0, 3) != 0) begin
        p0_if.req = 1'b1; p0_if.we = 1'($urandom_range(0, 1));
        p0_if.addr = rand_addr(); p0_if.wdata = 8'($urandom);
      end
      if (!p1_if.req && $urandom_range(0, 3) != 0) begin
        p1_if.req = 1'b1; p1_if.we = 1'($urandom_range(0, 1));
        p1_if.addr = rand_addr(); p1_if.wdata = 8'($urandom);
      end
      #1;
      eg = exp_gnt(p0_if.req, p1_if.req);
      checks++;
      if ({p1_if.gnt, p0_if.gnt} !== eg) begin
        errors++; $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, {p1_if.gnt, p0_if.gnt}, eg);
      end
      checks++;
      if (p0_if.rvalid !== (st2_v & ~st2_port) || p1_if.rvalid !== (st2_v & st2_port) ||
          (st2_v && (st2_port ? p1_if.rdata : p0_if.rdata) !== st2_data)) begin
        errors++;
        $display("FAIL rand_ret c=%0d got rv=%b%b rd0=%h rd1=%h exp v=%b port=%b rd=%h",
                 c, p1_if.rvalid, p0_if.rvalid, p0_if.rdata, p1_if.rdata, st2_v, st2_port, st2_data);
      end
      clk_step();
      if (eg[0]) p0_if.req = 1'b0;
      if (eg[1]) p1_if.req = 1'b0;
      if (c >= 396) begin
        p0_if.req = 1'b0; p1_if.req = 1'b0;
      end
    end
    repeat (2) clk_step();
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rand_mem got %0d differing bytes exp 0", bad);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = 16'h0; p0_if.wdata = 8'h0;
    p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = 16'h0; p1_if.wdata = 8'h0;
    model_reset();
    bd_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bd_addr = 8'(i);
      bd_data = (i == 16) ? 8'h5A : 8'($urandom);
      shadow[i] = bd_data;
      @(negedge clk);
    end
    bd_we = 1'b0;
    test_reset();
    test_contention();
    test_single_read();
    test_write_read();
    test_oob();
    test_reset_midpipe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
